// File: rtl/pll_seq_pkg.sv
// Shared state codes, saturation limits and a counter-width helper for the PLL lock sequencer.
package pll_seq_pkg;

    localparam logic [1:0] ST_RESET_HOLD = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK  = 2'd1;
    localparam logic [1:0] ST_LOCKED     = 2'd2;
    localparam logic [1:0] ST_BYPASS     = 2'd3;

    typedef enum logic [1:0] {
        RESET_HOLD = ST_RESET_HOLD,
        WAIT_LOCK  = ST_WAIT_LOCK,
        LOCKED     = ST_LOCKED,
        BYPASS     = ST_BYPASS
    } pll_state_t;

    localparam logic [3:0] RETRY_SAT = 4'd15;
    localparam logic [7:0] LOSS_SAT  = 8'd255;

    // Width needed to count 0 .. n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-wait / lock-monitor sequencer with retry and loss statistics.
// Optional bypass fallback after repeated timeouts: define PLL_SEQ_BYPASS_FALLBACK_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES   = 16,
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       clear_counts,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_resetn,
    output logic       locked,
    output logic [1:0] state,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    localparam bit FALLBACK_EN = 1'b1;
`else
    localparam bit FALLBACK_EN = 1'b0;
`endif

    localparam int HW = cntWidth(RESET_CYCLES);
    localparam int SW = cntWidth(STABLE_CYCLES);
    localparam int TW = cntWidth(TIMEOUT_CYCLES);

    pll_state_t  r_state;
    pll_state_t  w_next_state;
    logic [HW-1:0] r_hold;
    logic [SW-1:0] r_stable;
    logic [TW-1:0] r_timeout;
    logic [3:0]  r_retry;
    logic [7:0]  r_loss;
    logic        r_pll_resetb;
    logic        r_pll_bypass;
    logic        r_sys_resetn;
    logic        r_locked;

    logic w_lock_s;
    logic w_hold_done;
    logic w_stable_done;
    logic w_timeout;
    logic w_fallback;
    logic w_timeout_evt;
    logic w_loss_evt;
    logic w_lock_entry;
    logic w_pll_resetb;
    logic w_pll_bypass;
    logic w_sys_resetn;
    logic w_locked;

    sync_2ff u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (pll_lock),
        .o_sync  (w_lock_s)
    );

    assign w_hold_done   = (r_hold == HW'(RESET_CYCLES - 1));
    assign w_stable_done = w_lock_s && (r_stable == SW'(STABLE_CYCLES - 1));
    assign w_timeout     = (r_timeout == TW'(TIMEOUT_CYCLES - 1));
    assign w_fallback    = FALLBACK_EN && (r_retry == 4'(MAX_RETRIES));

    // Stable completion has priority over a coincident timeout.
    assign w_lock_entry  = (r_state == WAIT_LOCK) && w_stable_done;
    assign w_timeout_evt = (r_state == WAIT_LOCK) && !w_stable_done && w_timeout;
    assign w_loss_evt    = (r_state == LOCKED) && !w_lock_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= RESET_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RESET_HOLD: if (w_hold_done) w_next_state = WAIT_LOCK;
            WAIT_LOCK: begin
                if (w_stable_done) begin
                    w_next_state = LOCKED;
                end else if (w_timeout) begin
                    w_next_state = w_fallback ? BYPASS : RESET_HOLD;
                end
            end
            LOCKED:     if (!w_lock_s) w_next_state = RESET_HOLD;
            BYPASS:     w_next_state = FALLBACK_EN ? BYPASS : RESET_HOLD;
            default:    w_next_state = RESET_HOLD;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_pll_resetb = 1'b1;
        w_pll_bypass = 1'b0;
        w_sys_resetn = 1'b0;
        w_locked     = 1'b0;
        case (w_next_state)
            RESET_HOLD: w_pll_resetb = 1'b0;
            LOCKED: begin
                w_sys_resetn = 1'b1;
                w_locked     = 1'b1;
            end
            BYPASS: begin
                w_sys_resetn = 1'b1;
                w_pll_bypass = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pll_resetb <= 1'b0;
            r_pll_bypass <= 1'b0;
            r_sys_resetn <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_pll_resetb <= w_pll_resetb;
            r_pll_bypass <= w_pll_bypass;
            r_sys_resetn <= w_sys_resetn;
            r_locked     <= w_locked;
        end
    end

    // Phase counters restart on every state change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold    <= '0;
            r_stable  <= '0;
            r_timeout <= '0;
        end else if (w_next_state != r_state) begin
            r_hold    <= '0;
            r_stable  <= '0;
            r_timeout <= '0;
        end else begin
            if (r_state == RESET_HOLD) begin
                r_hold <= r_hold + 1'b1;
            end
            if (r_state == WAIT_LOCK) begin
                r_stable  <= w_lock_s ? r_stable + 1'b1 : '0;
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_retry <= 4'd0;
            r_loss  <= 8'd0;
        end else if (clear_counts) begin
            r_retry <= 4'd0;
            r_loss  <= 8'd0;
        end else begin
            if (w_lock_entry) begin
                r_retry <= 4'd0;
            end else if (w_timeout_evt && (r_retry != RETRY_SAT)) begin
                r_retry <= r_retry + 4'd1;
            end
            if (w_loss_evt && (r_loss != LOSS_SAT)) begin
                r_loss <= r_loss + 8'd1;
            end
        end
    end

    assign pll_resetb  = r_pll_resetb;
    assign pll_bypass  = FALLBACK_EN ? r_pll_bypass : 1'b0;
    assign sys_resetn  = r_sys_resetn;
    assign locked      = r_locked;
    assign state       = r_state;
    assign retry_count = r_retry;
    assign loss_count  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus randomized lock patterns vs. a reference model.
module tb_pll_lock_sequencer;

    localparam int RESET_CYCLES   = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int MAX_RETRIES    = 2;

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       clear_counts;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_resetn;
    logic       locked;
    logic [1:0] state;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, cycles spent in phase, lock run length, statistics, sync pipeline.
    int mState;
    int mAge;
    int mRun;
    int mRetry;
    int mLoss;
    bit mS1;
    bit mS2;

    pll_lock_sequencer #(
        .RESET_CYCLES   (RESET_CYCLES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_lock     (pll_lock),
        .clear_counts (clear_counts),
        .pll_resetb   (pll_resetb),
        .pll_bypass   (pll_bypass),
        .sys_resetn   (sys_resetn),
        .locked       (locked),
        .state        (state),
        .retry_count  (retry_count),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mAge   = 0;
        mRun   = 0;
        mRetry = 0;
        mLoss  = 0;
        mS1    = 1'b0;
        mS2    = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic modelStep();
        int  nxt;
        int  run2;
        bit  lockS;
        bit  tmo;
        bit  loss;
        bit  enter;
        lockS = mS2;
        nxt   = mState;
        run2  = 0;
        tmo   = 1'b0;
        loss  = 1'b0;
        enter = 1'b0;
        case (mState)
            0: if (mAge + 1 == RESET_CYCLES) nxt = 1;
            1: begin
                run2 = lockS ? mRun + 1 : 0;
                if (run2 == STABLE_CYCLES) begin
                    nxt   = 2;
                    enter = 1'b1;
                end else if (mAge + 1 == TIMEOUT_CYCLES) begin
                    tmo = 1'b1;
                    nxt = (BYPASS_EN && mRetry == MAX_RETRIES) ? 3 : 0;
                end
            end
            2: if (!lockS) begin
                nxt  = 0;
                loss = 1'b1;
            end
            default: ;
        endcase
        if (nxt != mState) begin
            mAge = 0;
            mRun = 0;
        end else begin
            mAge = mAge + 1;
            mRun = run2;
        end
        if (clear_counts) begin
            mRetry = 0;
            mLoss  = 0;
        end else begin
            if (enter) mRetry = 0;
            if (tmo && mRetry < 15) mRetry = mRetry + 1;
            if (loss && mLoss < 255) mLoss = mLoss + 1;
        end
        mState = nxt;
        mS2 = mS1;
        mS1 = pll_lock;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_state"},       state,       mState);
        checkOutput({tag, "_pll_resetb"},  pll_resetb,  (mState != 0));
        checkOutput({tag, "_pll_bypass"},  pll_bypass,  (mState == 3));
        checkOutput({tag, "_sys_resetn"},  sys_resetn,  (mState == 2 || mState == 3));
        checkOutput({tag, "_locked"},      locked,      (mState == 2));
        checkOutput({tag, "_retry_count"}, retry_count, mRetry);
        checkOutput({tag, "_loss_count"},  loss_count,  mLoss);
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, compare, return to the falling edge.
    task automatic applyStimulus(input logic lockVal, input logic clrVal);
        pll_lock     = lockVal;
        clear_counts = clrVal;
        @(posedge clk);
        modelStep();
        #1;
        checkModel("model");
        @(negedge clk);
    endtask

    task automatic runCycles(input int n, input logic lockVal);
        for (int i = 0; i < n; i++) begin
            applyStimulus(lockVal, 1'b0);
        end
    endtask

    task automatic applyReset(input logic lockVal);
        resetn       = 1'b0;
        pll_lock     = lockVal;
        clear_counts = 1'b0;
        #1;
        modelReset();
        checkModel("async_reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int   runLeft;
        logic lvl;
        logic clr;
        resetn       = 1'b0;
        pll_lock     = 1'b0;
        clear_counts = 1'b0;
        runLeft      = 0;
        lvl          = 1'b1;
        modelReset();
        @(negedge clk);

        $display("[TB] lock with pll_lock held high from reset");
        applyReset(1'b1);
        runCycles(3, 1'b1);
        checkOutput("hold_pll_resetb_low", pll_resetb, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("hold_done_pll_resetb", pll_resetb, 1);
        checkOutput("hold_done_state", state, 1);
        runCycles(7, 1'b1);
        checkOutput("pre_lock_sys_resetn", sys_resetn, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("lock_sys_resetn", sys_resetn, 1);
        checkOutput("lock_locked", locked, 1);
        checkOutput("lock_state", state, 2);

        $display("[TB] lock loss and clear_counts collision");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("loss_sync_delay_sys_resetn", sys_resetn, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("loss_sys_resetn", sys_resetn, 0);
        checkOutput("loss_count_one", loss_count, 1);
        checkOutput("loss_state", state, 0);
        checkOutput("loss_pll_resetb", pll_resetb, 0);
        runCycles(11, 1'b1);
        checkOutput("relock_pending_state", state, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("relock_state", state, 2);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("clear_beats_loss_incr", loss_count, 0);
        checkOutput("clear_loss_state", state, 0);

        $display("[TB] one-cycle lock glitch at stable count 5");
        applyReset(1'b1);
        runCycles(7, 1'b1);
        applyStimulus(1'b0, 1'b0);
        runCycles(4, 1'b1);
        checkOutput("glitch_no_early_lock", state, 1);
        runCycles(5, 1'b1);
        checkOutput("glitch_still_waiting", state, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("glitch_lock_after_8", state, 2);

        $display("[TB] timeout then lock clears retry_count");
        applyReset(1'b0);
        runCycles(36, 1'b0);
        checkOutput("first_timeout_retry", retry_count, 1);
        runCycles(12, 1'b1);
        checkOutput("late_lock_state", state, 2);
        checkOutput("lock_clears_retry", retry_count, 0);

        $display("[TB] pll_lock held low: repeated timeouts");
        applyReset(1'b0);
        runCycles(35, 1'b0);
        checkOutput("pre_timeout_retry", retry_count, 0);
        checkOutput("pre_timeout_state", state, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("timeout1_retry", retry_count, 1);
        checkOutput("timeout1_state", state, 0);
        runCycles(36, 1'b0);
        checkOutput("timeout2_retry", retry_count, 2);
        runCycles(36, 1'b0);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
        checkOutput("bypass_state", state, 3);
        checkOutput("bypass_pll_bypass", pll_bypass, 1);
        checkOutput("bypass_sys_resetn", sys_resetn, 1);
        checkOutput("bypass_pll_resetb", pll_resetb, 1);
        checkOutput("bypass_locked", locked, 0);
        runCycles(50, 1'b1);
        checkOutput("bypass_persists", state, 3);
`else
        checkOutput("timeout3_retry", retry_count, 3);
        checkOutput("timeout3_state", state, 0);
        for (int k = 4; k <= 17; k++) begin
            runCycles(36, 1'b0);
            checkOutput("retry_saturation", retry_count, (k > 15) ? 15 : k);
            checkOutput("never_bypass", pll_bypass, 0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("clear_retry", retry_count, 0);
`endif

        $display("[TB] randomized lock patterns against reference model");
        applyReset(1'b1);
        for (int i = 0; i < 1500; i++) begin
            if (runLeft == 0) begin
                lvl     = 1'($urandom_range(0, 1));
                runLeft = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            end
            runLeft = runLeft - 1;
            clr = ($urandom_range(0, 63) == 0);
            applyStimulus(lvl, clr);
            if (i == 700) begin
                applyReset(lvl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset; it SHALL have the parameters and ports listed below.
REQ-002 Parameter RESET_CYCLES, default 16: cycles to hold pll_resetb low.
REQ-003 Parameter STABLE_CYCLES, default 64: consecutive synchronized-lock cycles required before lock is declared.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent in WAIT_LOCK per attempt.
REQ-005 Parameter MAX_RETRIES, default 3: number of timed-out attempts tolerated before bypass fallback.
REQ-006 clk  in  1  PLL reference clock; sole clock of the block.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 pll_lock  in  1  PLL LOCK output, asynchronous to clk.
REQ-009 clear_counts  in  1  synchronous clear of retry_count and loss_count.
REQ-010 pll_resetb  out  1  drives the PLL RESETB input.
REQ-011 pll_bypass  out  1  drives the PLL BYPASS input.
REQ-012 sys_resetn  out  1  active-low system reset request.
REQ-013 locked  out  1  high while in LOCKED.
REQ-014 state  out  2  current state code.
REQ-015 retry_count  out  4  count of timed-out attempts.
REQ-016 loss_count  out  8  count of lock losses seen in LOCKED.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer, giving lock_s; all decisions SHALL use lock_s only.
REQ-018 States SHALL be RESET_HOLD=0, WAIT_LOCK=1, LOCKED=2, BYPASS=3.
REQ-019 RESET_HOLD SHALL drive pll_resetb=0 for exactly RESET_CYCLES cycles and then enter WAIT_LOCK.
REQ-020 In WAIT_LOCK, the stable counter SHALL increment on lock_s=1 and clear on lock_s=0; the timeout counter SHALL increment every cycle. Both counters SHALL clear on entry.
REQ-021 When lock_s=1 for STABLE_CYCLES consecutive cycles, the next state SHALL be LOCKED.
REQ-022 When TIMEOUT_CYCLES elapse without REQ-021 firing, the next state SHALL be RESET_HOLD and retry_count SHALL increment, saturating at 15.
REQ-023 If stable completion and timeout occur in the same cycle, stable completion SHALL win.
REQ-024 In LOCKED, lock_s=0 SHALL cause the next state to be RESET_HOLD and loss_count SHALL increment, saturating at 255.
REQ-025 Entry into LOCKED SHALL clear retry_count.
REQ-026 All outputs SHALL be registered: sys_resetn=1 and locked=1 exactly while state is LOCKED; pll_resetb=0 exactly while state is RESET_HOLD.
REQ-027 clear_counts SHALL zero both counters on the next edge and SHALL win over a simultaneous increment.

Reset
REQ-028 While resetn=0, the block SHALL hold state=RESET_HOLD, pll_resetb=0, pll_bypass=0, sys_resetn=0, locked=0, with all counters and synchronizer flops at 0.
REQ-029 Deassertion of resetn SHALL start a full RESET_CYCLES hold; assertion of resetn in any state SHALL take effect immediately.

Configuration
REQ-030 Macro PLL_SEQ_BYPASS_FALLBACK_EN defined: a timeout that occurs with retry_count == MAX_RETRIES SHALL enter BYPASS instead of RESET_HOLD. BYPASS SHALL drive pll_bypass=1, pll_resetb=1, sys_resetn=1 and locked=0, and SHALL be left only via resetn.
REQ-031 Macro undefined: BYPASS SHALL be unreachable, pll_bypass SHALL be constant 0, and retries SHALL continue indefinitely.

Structure
REQ-032 A shared package pll_seq_pkg SHALL hold the state enum typedef and the state-code constants.
REQ-033 The synchronizer SHALL be a sub-module named sync_2ff.

Verification
Bench parameters: RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-034 Release resetn with pll_lock=1 held -> pll_resetb low for 4 cycles; sys_resetn rises after the 8-cycle stable window plus sync latency; locked=1; state=2.
REQ-035 Lock glitch to 0 for 1 cycle at stable count 5 -> stable count restarts; LOCKED is reached 8 cycles after the glitch clears.
REQ-036 pll_lock held at 0 -> timeouts every 32+4 cycles; retry_count = 1, 2, 3 (macro off: keeps counting and saturates at 15).
REQ-037 Macro on, pll_lock held at 0 -> the third timeout enters BYPASS: pll_bypass=1, sys_resetn=1, state=3, which persists until resetn.
REQ-038 In LOCKED, drop pll_lock -> loss_count=1, sys_resetn=0 within 3 cycles, and a new RESET_HOLD begins; clear_counts pulsed in the same cycle as an increment -> loss_count=0.
